dpll_ctrl: RTL and testbench

DPLL_CTRL -- requirements
Module: dpll_ctrl

---
 rtl/dpll_ctrl_pkg.sv | 44 ++++
 rtl/dpll_ctrl_sync_edge.sv | 25 ++
 rtl/dpll_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dpll_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_ctrl_pkg.sv
// Shared register map, field positions and FSM encoding for the DPLL controller.
package dpll_ctrl_pkg;

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_WINDOW = 3'd1;
   localparam logic [2:0] OFF_STATUS = 3'd2;
   localparam logic [2:0] OFF_COUNT  = 3'd3;
   localparam logic [2:0] OFF_CMD    = 3'd4;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_RESETB_BIT = 1;
   localparam int CTRL_IRQEN_BIT  = 2;
   localparam int CTRL_DIV_LSB    = 4;
   localparam int CTRL_DIV_MSB    = 8;
   // Bit 3 of CTRL is unimplemented and always reads back 0.
   localparam logic [8:0] CTRL_WMASK = 9'h1F7;

   localparam int STAT_BUSY_BIT   = 0;
   localparam int STAT_DONE_BIT   = 1;
   localparam int STAT_LOCKED_BIT = 2;
   localparam int CMD_START_BIT   = 0;

   localparam logic [15:0] WINDOW_DEFAULT = 16'h0010;
   localparam int          PROD_W         = 21;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_MEASURE,
      ST_DONE
   } state_t;

   function automatic logic [31:0] merge_sel(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dpll_ctrl_sync_edge.sv
// Two-flop synchronizer for a slow asynchronous clock, followed by a rising-edge pulse.
module dpll_ctrl_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/dpll_ctrl.sv
// Wishbone-controlled DPLL configuration block with a feedback-frequency measurement engine.
module dpll_ctrl
   import dpll_ctrl_pkg::*;
#(
   parameter int CNT_W    = 20,
   parameter int LOCK_TOL = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        osc_i,
   input  logic        fb_i,
   output logic        dpll_resetb_o,
   output logic        dpll_enable_o,
   output logic [4:0]  dpll_div_o,
   output logic        irq_o
);

   localparam int CMP_W = (CNT_W > PROD_W) ? CNT_W : PROD_W;

   state_t            state_q, state_d;
   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic [8:0]        ctrl_q, ctrl_d;
   logic [15:0]       window_q, window_d;
   logic              done_q, done_d, locked_q, locked_d;
   logic [CNT_W-1:0]  count_q, count_d, cnt_q, cnt_d;
   logic [15:0]       osc_cnt_q, osc_cnt_d;

   logic              osc_rise, fb_rise;
   logic              access, wr, start, w1c_done, abort;
   logic [2:0]        off;
   logic              busy, cnt_clr, cnt_run, load_result;
   logic [31:0]       ctrl_merge, window_merge, rdata;
   logic [15:0]       win_eff;
   logic              osc_last;
   logic [4:0]        div;
   logic [PROD_W-1:0] prod;
   logic [CMP_W-1:0]  cnt_ext, exp_ext, diff;
   logic              within_tol;
   logic              unused_bits;

   dpll_ctrl_sync_edge u_sync_osc (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .async_i(osc_i),
      .rise_o (osc_rise)
   );

   dpll_ctrl_sync_edge u_sync_fb (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .async_i(fb_i),
      .rise_o (fb_rise)
   );

   // Valid/ready: a request is stb&cyc; it is accepted on a cycle where ack is low,
   // and answered by a single registered ack pulse carrying the read data.
   assign access   = wbs_stb_i & wbs_cyc_i & ~ack_q;
   assign wr       = access & wbs_we_i;
   assign off      = wbs_adr_i[4:2];
   assign start    = wr && (off == OFF_CMD) && wbs_dat_i[CMD_START_BIT];
   assign w1c_done = wr && (off == OFF_STATUS) && wbs_dat_i[STAT_DONE_BIT];

   assign div   = ctrl_q[CTRL_DIV_MSB:CTRL_DIV_LSB];
   assign abort = ~ctrl_q[CTRL_EN_BIT] | ~ctrl_q[CTRL_RESETB_BIT];

   assign ctrl_merge   = merge_sel({23'd0, ctrl_q}, wbs_dat_i, wbs_sel_i);
   assign window_merge = merge_sel({16'd0, window_q}, wbs_dat_i, wbs_sel_i);

   assign win_eff  = (window_q == 16'd0) ? 16'd1 : window_q;
   assign osc_last = ({1'b0, osc_cnt_q} + 17'd1) == {1'b0, win_eff};

   // Lock check is done wide enough that neither operand can wrap.
   assign prod       = PROD_W'(div) * PROD_W'(win_eff);
   assign cnt_ext    = CMP_W'(cnt_q);
   assign exp_ext    = CMP_W'(prod);
   assign diff       = (cnt_ext >= exp_ext) ? (cnt_ext - exp_ext) : (exp_ext - cnt_ext);
   assign within_tol = diff <= CMP_W'(LOCK_TOL);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start && ctrl_q[CTRL_EN_BIT]) state_d = ST_ARM;
         ST_ARM:     if (abort) state_d = ST_IDLE;
                     else if (osc_rise) state_d = ST_MEASURE;
         ST_MEASURE: if (abort) state_d = ST_IDLE;
                     else if (osc_rise && osc_last) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy        = 1'b1;
      cnt_clr     = 1'b0;
      cnt_run     = 1'b0;
      load_result = 1'b0;
      case (state_q)
         ST_IDLE:    busy = 1'b0;
         ST_ARM:     cnt_clr = 1'b1;
         ST_MEASURE: cnt_run = 1'b1;
         ST_DONE:    load_result = 1'b1;
         default:    busy = 1'b0;
      endcase
   end

   always_comb begin
      ctrl_d   = ctrl_q;
      window_d = window_q;
      if (wr && (off == OFF_CTRL))   ctrl_d   = ctrl_merge[8:0] & CTRL_WMASK;
      if (wr && (off == OFF_WINDOW)) window_d = window_merge[15:0];
   end

   // Result load sits after the W1C clear so a finishing measurement wins.
   always_comb begin
      cnt_d     = cnt_q;
      osc_cnt_d = osc_cnt_q;
      count_d   = count_q;
      locked_d  = locked_q;
      done_d    = done_q;
      if (cnt_clr) begin
         cnt_d     = '0;
         osc_cnt_d = '0;
      end else if (cnt_run) begin
         if (fb_rise && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
         if (osc_rise) osc_cnt_d = osc_cnt_q + 16'd1;
      end
      if (w1c_done) done_d = 1'b0;
      if (load_result) begin
         count_d  = cnt_q;
         locked_d = within_tol;
         done_d   = 1'b1;
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         OFF_CTRL:   rdata = {23'd0, ctrl_q};
         OFF_WINDOW: rdata = {16'd0, window_q};
         OFF_STATUS: begin
            rdata[STAT_BUSY_BIT]   = busy;
            rdata[STAT_DONE_BIT]   = done_q;
            rdata[STAT_LOCKED_BIT] = locked_q;
         end
         OFF_COUNT:  rdata = 32'(count_q);
         default:    rdata = '0;
      endcase
   end

   assign ack_d = access;
   assign dat_d = (access && !wbs_we_i) ? rdata : 32'd0;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         ctrl_q    <= '0;
         window_q  <= WINDOW_DEFAULT;
         done_q    <= 1'b0;
         locked_q  <= 1'b0;
         count_q   <= '0;
         cnt_q     <= '0;
         osc_cnt_q <= '0;
      end else begin
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         ctrl_q    <= ctrl_d;
         window_q  <= window_d;
         done_q    <= done_d;
         locked_q  <= locked_d;
         count_q   <= count_d;
         cnt_q     <= cnt_d;
         osc_cnt_q <= osc_cnt_d;
      end
   end

   assign wbs_ack_o     = ack_q;
   assign wbs_dat_o     = dat_q;
   assign dpll_enable_o = ctrl_q[CTRL_EN_BIT];
   assign dpll_resetb_o = ctrl_q[CTRL_RESETB_BIT];
   assign dpll_div_o    = div;
   assign irq_o         = done_q & ctrl_q[CTRL_IRQEN_BIT];

   assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], ctrl_merge[31:9], window_merge[31:16]};

endmodule

// File: tb/tb_dpll_ctrl.sv
// Directed bench for dpll_ctrl: register map, measurement, lock decision, abort and reset.
module tb_dpll_ctrl;
   import dpll_ctrl_pkg::*;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
   logic [3:0]  wbs_sel_i = 4'h0;
   logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        osc_i = 1'b0, fb_i = 1'b0;
   logic        dpll_resetb_o, dpll_enable_o, irq_o;
   logic [4:0]  dpll_div_o;

   int checks = 0;
   int failures = 0;
   int cyc_cnt = 0;
   int osc_half = 800;
   int fb_half = 100;

   dpll_ctrl #(.CNT_W(20), .LOCK_TOL(2)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .osc_i(osc_i), .fb_i(fb_i),
      .dpll_resetb_o(dpll_resetb_o), .dpll_enable_o(dpll_enable_o),
      .dpll_div_o(dpll_div_o), .irq_o(irq_o)
   );

   // Clock period 40; fb period 200 (5 clocks); osc period 1600 (8x) or 1610 (8.05x).
   always #20 wb_clk_i = ~wb_clk_i;
   always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;
   initial begin #3; forever #(fb_half) fb_i = ~fb_i; end
   initial begin #3; forever #(osc_half) osc_i = ~osc_i; end

   initial begin
      repeat (60000) @(posedge wb_clk_i);
      $display("FAIL watchdog cycles=%0d expected_finish_before=60000", cyc_cnt);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wb_access(input logic w, input logic [2:0] off, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] r);
      int n;
      @(negedge wb_clk_i);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = w;
      wbs_adr_i = {27'd0, off, 2'b00}; wbs_dat_i = d; wbs_sel_i = s;
      n = 0;
      do begin @(negedge wb_clk_i); n++; end while (!wbs_ack_o && n < 8);
      check("ack_latency", 32'(n), 32'd1);
      r = wbs_dat_o;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      @(negedge wb_clk_i);
      check("ack_single_cycle", {31'd0, wbs_ack_o}, 32'd0);
      check("dat_zero_no_ack", wbs_dat_o, 32'd0);
   endtask

   task automatic wb_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      wb_access(1'b1, off, d, s, r);
   endtask

   task automatic wb_read(input logic [2:0] off, output logic [31:0] r);
      wb_access(1'b0, off, 32'd0, 4'h0, r);
   endtask

   task automatic wait_idle(input int budget);
      logic [31:0] r;
      int t0;
      t0 = cyc_cnt;
      do wb_read(OFF_STATUS, r); while (r[STAT_BUSY_BIT] && (cyc_cnt - t0) < budget);
      check("busy_clears_in_budget", {31'd0, r[STAT_BUSY_BIT]}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"},    {31'd0, wbs_ack_o},     32'd0);
      check({tag, "_dat"},    wbs_dat_o,              32'd0);
      check({tag, "_resetb"}, {31'd0, dpll_resetb_o}, 32'd0);
      check({tag, "_enable"}, {31'd0, dpll_enable_o}, 32'd0);
      check({tag, "_div"},    {27'd0, dpll_div_o},    32'd0);
      check({tag, "_irq"},    {31'd0, irq_o},         32'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic [3:0]  ack_pat;
      int t0;

      // Reset and register defaults.
      repeat (3) @(negedge wb_clk_i);
      check_reset_outputs("in_reset");
      wb_rst_i = 1'b0;
      wb_read(OFF_CTRL, r);   check("rst_ctrl", r, 32'h0);
      wb_read(OFF_WINDOW, r); check("rst_window", r, 32'h10);
      wb_read(OFF_STATUS, r); check("rst_status", r, 32'h0);
      wb_read(OFF_COUNT, r);  check("rst_count", r, 32'h0);
      wb_read(OFF_CMD, r);    check("cmd_reads_zero", r, 32'h0);
      wb_read(3'd7, r);       check("unmapped_reads_zero", r, 32'h0);
      wb_write(3'd6, 32'hFFFF_FFFF, 4'hF);
      wb_read(OFF_CTRL, r);   check("unmapped_write_ignored", r, 32'h0);

      // CTRL fields and byte lanes.
      wb_write(OFF_CTRL, 32'h0000_0083, 4'hF);
      check("div_8", {27'd0, dpll_div_o}, 32'd8);
      check("resetb_1", {31'd0, dpll_resetb_o}, 32'd1);
      check("enable_1", {31'd0, dpll_enable_o}, 32'd1);
      wb_read(OFF_CTRL, r);   check("ctrl_0x83", r, 32'h83);
      wb_write(OFF_CTRL, 32'h0000_0187, 4'hF);
      check("div_0x18", {27'd0, dpll_div_o}, 32'h18);
      wb_write(OFF_CTRL, 32'h0, 4'b0001);
      wb_read(OFF_CTRL, r);   check("ctrl_sel_lane0", r, 32'h100);
      check("div_after_sel", {27'd0, dpll_div_o}, 32'h10);
      check("enable_after_sel", {31'd0, dpll_enable_o}, 32'd0);
      wb_write(OFF_CTRL, 32'hFFFF_FFFF, 4'hF);
      wb_read(OFF_CTRL, r);   check("ctrl_all_ones", r, 32'h1F7);
      wb_write(OFF_CTRL, 32'h0, 4'hF);

      // WINDOW byte lanes and back-to-back acks.
      wb_write(OFF_WINDOW, 32'h0000_ABCD, 4'b0010);
      wb_read(OFF_WINDOW, r); check("window_sel_lane1", r, 32'hAB10);
      @(negedge wb_clk_i);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = {27'd0, OFF_WINDOW, 2'b00};
      for (int i = 0; i < 4; i++) begin
         @(negedge wb_clk_i);
         ack_pat[3-i] = wbs_ack_o;
         if (i == 0) check("b2b_first_data", wbs_dat_o, 32'hAB10);
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      check("b2b_ack_pattern", {28'd0, ack_pat}, 32'hA);

      // Exact 8x, WINDOW=100: lock expected.
      wb_write(OFF_CTRL, 32'h87, 4'hF);
      wb_write(OFF_WINDOW, 32'd100, 4'hF);
      wb_write(OFF_CMD, 32'h1, 4'hF);
      wb_read(OFF_STATUS, r); check("busy_after_start", r, 32'h1);
      check("irq_low_while_busy", {31'd0, irq_o}, 32'd0);
      wait_idle(4600);
      wb_read(OFF_COUNT, r);  check("count_800", r, 32'd800);
      wb_read(OFF_STATUS, r); check("status_done_locked", r, 32'h6);
      check("irq_high", {31'd0, irq_o}, 32'd1);
      wb_write(OFF_STATUS, 32'h2, 4'hF);
      wb_read(OFF_STATUS, r); check("w1c_done", r, 32'h4);
      check("irq_cleared", {31'd0, irq_o}, 32'd0);

      // 8.05x: about 805 edges, outside tolerance.
      osc_half = 805;
      repeat (100) @(negedge wb_clk_i);
      wb_write(OFF_CMD, 32'h1, 4'hF);
      wait_idle(4700);
      wb_read(OFF_COUNT, r);
      check("count_near_805", {31'd0, (r >= 32'd804 && r <= 32'd806)}, 32'd1);
      wb_read(OFF_STATUS, r); check("status_done_unlocked", r, 32'h2);
      wb_write(OFF_STATUS, 32'h2, 4'hF);

      // WINDOW=0 behaves as one osc period.
      osc_half = 800;
      repeat (100) @(negedge wb_clk_i);
      wb_write(OFF_WINDOW, 32'd0, 4'hF);
      wb_write(OFF_CMD, 32'h1, 4'hF);
      wait_idle(200);
      wb_read(OFF_COUNT, r);  check("count_window0", r, 32'd8);
      wb_read(OFF_STATUS, r); check("status_window0", r, 32'h6);
      wb_write(OFF_STATUS, 32'h2, 4'hF);

      // A second start while busy must not restart the measurement.
      wb_write(OFF_WINDOW, 32'd10, 4'hF);
      wb_write(OFF_CMD, 32'h1, 4'hF);
      t0 = cyc_cnt;
      repeat (200) @(negedge wb_clk_i);
      wb_write(OFF_CMD, 32'h1, 4'hF);
      wait_idle(600);
      check("no_restart_duration", {31'd0, (cyc_cnt - t0) <= 500}, 32'd1);
      wb_read(OFF_COUNT, r);  check("count_80", r, 32'd80);
      wb_write(OFF_STATUS, 32'h2, 4'hF);

      // Abort by clearing enable mid-measurement.
      wb_write(OFF_CMD, 32'h1, 4'hF);
      repeat (100) @(negedge wb_clk_i);
      wb_write(OFF_CTRL, 32'h86, 4'hF);
      wb_read(OFF_STATUS, r); check("abort_idle", r, 32'h4);
      repeat (500) @(negedge wb_clk_i);
      wb_read(OFF_STATUS, r); check("abort_done_stays_0", r, 32'h4);
      wb_read(OFF_COUNT, r);  check("abort_count_kept", r, 32'd80);
      wb_write(OFF_CMD, 32'h1, 4'hF);
      wb_read(OFF_STATUS, r); check("start_ignored_disabled", r, 32'h4);

      // Reset during a measurement and during an access.
      wb_write(OFF_CTRL, 32'h87, 4'hF);
      wb_write(OFF_CMD, 32'h1, 4'hF);
      repeat (50) @(negedge wb_clk_i);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = {27'd0, OFF_CTRL, 2'b00};
      @(posedge wb_clk_i);
      #5;
      check("ack_before_reset", {31'd0, wbs_ack_o}, 32'd1);
      wb_rst_i = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      repeat (3) @(negedge wb_clk_i);
      check("ack_held_in_reset", {31'd0, wbs_ack_o}, 32'd0);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      wb_rst_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);
      check("no_stray_ack", {31'd0, wbs_ack_o}, 32'd0);
      wb_read(OFF_STATUS, r); check("post_reset_status", r, 32'h0);
      wb_read(OFF_COUNT, r);  check("post_reset_count", r, 32'h0);
      wb_read(OFF_WINDOW, r); check("post_reset_window", r, 32'h10);
      wb_read(OFF_CTRL, r);   check("post_reset_ctrl", r, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
